ifu_axi_fetch: RTL
==================

IFU_AXI_FETCH -- requirements
Module: ifu_axi_fetch

Interface
REQ-001 RESET_PC, 32'h8000_0000, SHALL be the address of the first fetch after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 araddr  output  32  SHALL be the AXI-lite read address to instruction memory.
REQ-005 arvalid  output  1  SHALL be the AXI-lite read address valid.
REQ-006 arready  input  1  SHALL be the read address ready from the slave.
REQ-007 rdata  input  32  SHALL be the read data (instruction word).
REQ-008 rresp  input  2  SHALL be the read response (2'b00 = OKAY).
REQ-009 rvalid  input  1  SHALL be the read data valid.
REQ-010 rready  output  1  SHALL be the read data ready.
REQ-011 redirect_valid  input  1  SHALL request a fetch redirect (branch/jump/trap).
REQ-012 redirect_pc  input  32  SHALL be the redirect target, sampled when redirect_valid=1.
REQ-013 inst_valid  output  1  SHALL flag a fetched instruction available to decode.
REQ-014 inst_ready  input  1  SHALL be decode acceptance; transfer occurs when inst_valid & inst_ready.
REQ-015 inst  output  32  SHALL be the held instruction word.
REQ-016 inst_pc  output  32  SHALL be the address the held instruction was fetched from.
REQ-017 inst_fault  output  1  SHALL flag that the held instruction returned rresp != OKAY.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, HOLD; registers pc, areg (32b), discard (1b).
REQ-019 IDLE SHALL unconditionally go to REQ next cycle, loading areg <= pc.
REQ-020 araddr SHALL equal areg; arvalid SHALL equal (state==REQ); rready SHALL equal (state==WAIT).
REQ-021 Once arvalid=1, araddr SHALL stay stable until the AR handshake (arvalid & arready).
REQ-022 REQ SHALL go to WAIT on the AR handshake; otherwise stay in REQ.
REQ-023 WAIT with rvalid=1, discard=0, redirect_valid=0 SHALL capture inst <= rdata, inst_fault <= (rresp!=0), and go to HOLD.
REQ-024 WAIT with rvalid=1 and (discard=1 or redirect_valid=1) SHALL drop rdata, clear discard, load areg <= pc (or redirect_pc), and go to REQ.
REQ-025 inst_valid SHALL equal (state==HOLD) & !redirect_valid; inst_pc SHALL equal areg.
REQ-026 HOLD with inst_ready=1 and no redirect SHALL set pc <= pc+4, areg <= pc+4, and go to REQ.
REQ-027 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-028 A redirect in any state SHALL set pc <= redirect_pc; redirect beats inst_ready in the same cycle.
REQ-029 A redirect in REQ (with or without arready) or in WAIT without rvalid SHALL set discard=1; the outstanding AR SHALL still complete and its response SHALL be dropped.
REQ-030 A redirect in HOLD SHALL drop the held instruction, load areg <= redirect_pc, and go to REQ.
REQ-031 The block SHALL keep at most one read outstanding and SHALL NOT issue AW/W transactions.
REQ-032 Minimum throughput SHALL be one instruction per 3 cycles with a zero-wait-state slave.

Reset
REQ-033 While rst=1: state=IDLE, pc=RESET_PC, areg=RESET_PC, discard=0, inst=0, inst_fault=0, arvalid=0, rready=0, inst_valid=0.
REQ-034 Reset asserted mid-transaction SHALL abort it immediately; a response arriving after reset release SHALL never be delivered as an instruction.

Verification
REQ-035 Reset release, arready=1, rvalid one cycle after AR with rdata=32'h0000_0013 -> araddr=32'h8000_0000, then inst_valid=1, inst=32'h13, inst_pc=32'h8000_0000, inst_fault=0.
REQ-036 inst_ready held 0 for 5 cycles in HOLD -> inst/inst_pc stable, arvalid=0; inst_ready=1 -> next araddr=32'h8000_0004.
REQ-037 arready low 4 cycles with redirect_valid pulse (redirect_pc=32'h8000_0100) in cycle 2 -> araddr stays 32'h8000_0000 until handshake, response dropped, next araddr=32'h8000_0100.
REQ-038 rresp=2'b10 -> inst_valid=1 with inst_fault=1 and pc advances by 4 on acceptance.
REQ-039 redirect_valid and inst_ready both 1 in HOLD -> no transfer, next araddr=redirect_pc.
REQ-040 redirect to 32'hFFFF_FFFC, instruction accepted -> next araddr=32'h0000_0000.

Source files
------------

// File: rtl/ifu_axi_fetch.sv
// Instruction fetch unit: walks the PC through an AXI-lite read channel and
// hands one instruction at a time to decode, with redirect and fault tagging.
module ifu_axi_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault
);

    // state | meaning
    // IDLE  | one cycle after reset, latch fetch address
    // REQ   | AR channel driven, waiting for arready
    // WAIT  | one read outstanding, waiting for rvalid
    // HOLD  | instruction held for decode
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] areg_q;
    logic        discard_q;
    logic [31:0] inst_q;
    logic        inst_fault_q;
    logic [31:0] pc_inc_d;

    assign pc_inc_d = pc_q + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            areg_q       <= RESET_PC;
            discard_q    <= 1'b0;
            inst_q       <= 32'h0;
            inst_fault_q <= 1'b0;
        end else begin
            if (redirect_valid) begin
                pc_q <= redirect_pc;
            end
            case (state_q)
                IDLE: begin
                    areg_q  <= redirect_valid ? redirect_pc : pc_q;
                    state_q <= REQ;
                end
                REQ: begin
                    // araddr must not move while arvalid is up, so a redirect
                    // here only marks the in-flight response for dropping.
                    if (redirect_valid) begin
                        discard_q <= 1'b1;
                    end
                    if (arready) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (rvalid) begin
                        if (discard_q || redirect_valid) begin
                            discard_q <= 1'b0;
                            areg_q    <= redirect_valid ? redirect_pc : pc_q;
                            state_q   <= REQ;
                        end else begin
                            inst_q       <= rdata;
                            inst_fault_q <= (rresp != RESP_OKAY);
                            state_q      <= HOLD;
                        end
                    end else if (redirect_valid) begin
                        discard_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        areg_q  <= redirect_pc;
                        state_q <= REQ;
                    end else if (inst_ready) begin
                        pc_q    <= pc_inc_d;
                        areg_q  <= pc_inc_d;
                        state_q <= REQ;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign araddr     = areg_q;
    assign arvalid    = (state_q == REQ);
    assign rready     = (state_q == WAIT);
    assign inst_valid = (state_q == HOLD) && !redirect_valid;
    assign inst       = inst_q;
    assign inst_pc    = areg_q;
    assign inst_fault = inst_fault_q;

endmodule
